// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the instruction fetch unit, its prefetch FIFO
// and the bus interface.
//   INSTR_W       - instruction word width
//   MEM_LAT       - program memory read latency in cycles (memory is synchronous)
//   HALT_WORD_DEF - default encoding of the HALT instruction
//   fetch_state_e - fetch controller states
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int MEM_LAT = 1;
  localparam logic [INSTR_W-1:0] HALT_WORD_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: groups the program-memory read port and the processor-side
// instruction handshake of the fetch unit.
//   master - fetch unit side: drives mem_rd/mem_addr, iin/iin_valid, pc,
//            halted and underrun; receives run, done and mem_data.
//   slave  - environment side (processor control + program memory).
interface instr_fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic               run;
  logic               done;
  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_data;
  logic [INSTR_W-1:0] iin;
  logic               iin_valid;
  logic [ADDR_W-1:0]  pc;
  logic               halted;
  logic               underrun;

  modport master (
    input  run, done, mem_data,
    output mem_rd, mem_addr, iin, iin_valid, pc, halted, underrun
  );

  modport slave (
    output run, done, mem_data,
    input  mem_rd, mem_addr, iin, iin_valid, pc, halted, underrun
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small prefetch FIFO holding fetched instruction words.
//   clock/resetn - system clock, asynchronous active-low reset
//   push/wdata   - write a word at the tail
//   pop          - drop the head word (ignored when empty)
//   flush        - discard all contents; takes priority over push/pop
//   head         - word at the head (stale data when empty)
//   count/empty/full - occupancy status
// Push and pop in the same cycle are both honoured, leaving count unchanged.
module fetch_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // A push into a full FIFO is only accepted when a pop frees the slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction supplier for the processor's iin port.
// Holds the PC, issues sequential reads to a synchronous program memory,
// buffers returned words in a prefetch FIFO and presents the head word until
// the processor pulses done. Fetch stops once a HALT word has been fetched.
//   clock  - system clock
//   resetn - asynchronous active-low reset
//   bus    - instr_fetch_if.master: run/done control, memory read port,
//            iin/iin_valid, pc, halted, underrun
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W     = 8,
  parameter int                 DEPTH      = 2,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0,
  parameter logic [INSTR_W-1:0] HALT_WORD  = HALT_WORD_DEF
) (
  input  logic          clock,
  input  logic          resetn,
  instr_fetch_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_rd_q, mem_rd_d;
  logic [MEM_LAT-1:0] inflight_q, inflight_d;
  logic               halt_fetched_q, halt_fetched_d;
  logic               halted_q, halted_d;
  logic               underrun_q, underrun_d;

  logic               fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
  logic [INSTR_W-1:0] fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               start, head_is_halt, iin_valid, push_is_halt, issue;
  int                 occupancy;

  fetch_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .flush  (fifo_flush),
    .wdata  (bus.mem_data),
    .head   (fifo_head),
    .count  (fifo_count),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assign start        = (state_q == ST_IDLE) && bus.run;
  assign head_is_halt = !fifo_empty && (fifo_head == HALT_WORD);
  assign iin_valid    = !fifo_empty && !head_is_halt;
  // Data of a read that was outstanding when fetch restarts is discarded.
  assign fifo_push    = inflight_q[MEM_LAT-1] && !start;
  assign fifo_pop     = bus.done && iin_valid;
  assign fifo_flush   = start;
  assign push_is_halt = fifo_push && (bus.mem_data == HALT_WORD);

  // Outstanding reads count against FIFO space so a returning word always
  // has a slot; the count used is the pre-pop value.
  always_comb begin
    occupancy = int'(fifo_count) + int'(mem_rd_q) + $countones(inflight_q);
    issue = start ||
            ((state_q == ST_RUN) && bus.run && !halt_fetched_q && !push_is_halt &&
             !fifo_full && (occupancy < DEPTH));
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    mem_addr_d     = mem_addr_q;
    mem_rd_d       = issue;
    inflight_d     = MEM_LAT'({inflight_q, mem_rd_q});
    halt_fetched_d = halt_fetched_q || push_is_halt;
    halted_d       = halted_q;
    underrun_d     = underrun_q || (bus.done && !iin_valid);

    if (start) begin
      inflight_d     = '0;
      halt_fetched_d = 1'b0;
      underrun_d     = 1'b0;
      pc_d           = START_ADDR;
    end

    if (issue) begin
      mem_addr_d = start ? START_ADDR : pc_q;
      pc_d       = mem_addr_d + ADDR_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.run) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (head_is_halt) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else if (!bus.run) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (head_is_halt) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else if (bus.run) begin
          state_d = ST_RUN;
        end else if (fifo_empty && !mem_rd_q && (inflight_q == '0)) begin
          state_d = ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (!bus.run) begin
          state_d  = ST_IDLE;
          halted_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      pc_q           <= START_ADDR;
      mem_addr_q     <= '0;
      mem_rd_q       <= 1'b0;
      inflight_q     <= '0;
      halt_fetched_q <= 1'b0;
      halted_q       <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      mem_addr_q     <= mem_addr_d;
      mem_rd_q       <= mem_rd_d;
      inflight_q     <= inflight_d;
      halt_fetched_q <= halt_fetched_d;
      halted_q       <= halted_d;
      underrun_q     <= underrun_d;
    end
  end

  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.iin       = fifo_head;
  assign bus.iin_valid = iin_valid;
  assign bus.pc        = pc_q;
  assign bus.halted    = halted_q;
  assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch.
// dut0 fetches from address 0, dut1 starts at 8'hFE to exercise PC wrap.
// Each DUT has a 1-cycle synchronous program memory model. Expected
// instruction words are queued per DUT and compared whenever a done pulse
// pops a valid instruction.
module tb_instr_fetch;

  logic clock;
  logic resetn;

  int check_count = 0;
  int error_count = 0;

  logic [15:0] sb0 [$];
  logic [15:0] sb1 [$];
  logic [7:0]  addr_seq0 [$];
  logic [7:0]  addr_seq1 [$];

  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];

  typedef struct {
    logic        run;
    logic        done;
    logic        exp_rd;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_pc;
    logic        exp_valid;
    logic [15:0] exp_iin;
  } vec_t;

  vec_t lat_vec [6];

  instr_fetch_if #(.ADDR_W(8)) if0 ();
  instr_fetch_if #(.ADDR_W(8)) if1 ();

  instr_fetch #(
    .ADDR_W(8), .DEPTH(2), .START_ADDR(8'h00), .HALT_WORD(16'hFFFF)
  ) dut0 (
    .clock(clock), .resetn(resetn), .bus(if0)
  );

  instr_fetch #(
    .ADDR_W(8), .DEPTH(2), .START_ADDR(8'hFE), .HALT_WORD(16'hFFFF)
  ) dut1 (
    .clock(clock), .resetn(resetn), .bus(if1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous program memories with one cycle of read latency.
  always @(posedge clock) begin
    if (!resetn) begin
      if0.mem_data <= 16'h0000;
      if1.mem_data <= 16'h0000;
    end else begin
      if (if0.mem_rd) if0.mem_data <= mem0[if0.mem_addr];
      if (if1.mem_rd) if1.mem_data <= mem1[if1.mem_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboard side: every accepted done pops the expected word.
  always @(negedge clock) begin
    if (resetn && if0.done && if0.iin_valid) begin
      if (sb0.size() == 0) begin
        check_count++;
        error_count++;
        $display("[TB] FAIL sb0 unexpected pop: got %0h, expected none", if0.iin);
      end else begin
        checkOutput("sb0 iin", if0.iin, sb0.pop_front());
      end
    end
    if (resetn && if1.done && if1.iin_valid) begin
      if (sb1.size() == 0) begin
        check_count++;
        error_count++;
        $display("[TB] FAIL sb1 unexpected pop: got %0h, expected none", if1.iin);
      end else begin
        checkOutput("sb1 iin", if1.iin, sb1.pop_front());
      end
    end
    if (if0.mem_rd) addr_seq0.push_back(if0.mem_addr);
    if (if1.mem_rd) addr_seq1.push_back(if1.mem_addr);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int sel, input logic run, input logic done);
    if (sel == 0) begin
      if0.run  = run;
      if0.done = done;
    end else begin
      if1.run  = run;
      if1.done = done;
    end
  endtask

  // Pops `words` instructions, each done pulse three cycles after the word is valid.
  task automatic spacedDone(input int sel, input int words);
    for (int k = 0; k < words; k++) begin
      int n = 0;
      while (!(sel == 0 ? if0.iin_valid : if1.iin_valid) && n < 20) begin
        step();
        n++;
      end
      checkOutput($sformatf("dut%0d valid wait %0d", sel, k),
                  (sel == 0 ? if0.iin_valid : if1.iin_valid), 1);
      repeat (3) step();
      applyStimulus(sel, 1'b1, 1'b1);
      step();
      applyStimulus(sel, 1'b1, 1'b0);
    end
  endtask

  task automatic waitHalted(input int sel);
    int n = 0;
    while (!(sel == 0 ? if0.halted : if1.halted) && n < 30) begin
      step();
      n++;
    end
    checkOutput($sformatf("dut%0d halted", sel), (sel == 0 ? if0.halted : if1.halted), 1);
  endtask

  initial begin
    int base;
    int max_addr;

    for (int i = 0; i < 256; i++) begin
      mem0[i] = 16'hDEAD;
      mem1[i] = 16'hDEAD;
    end
    mem0[0] = 16'h1111; mem0[1] = 16'h2222; mem0[2] = 16'h3333; mem0[3] = 16'hFFFF;
    mem1[8'hFE] = 16'hAAAA; mem1[8'hFF] = 16'hBBBB; mem1[8'h00] = 16'hFFFF;

    lat_vec[0] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 16'h0000};
    lat_vec[1] = '{1'b1, 1'b0, 1'b1, 8'h01, 8'h02, 1'b0, 16'h0000};
    lat_vec[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 16'h1111};
    lat_vec[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 16'h1111};
    lat_vec[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 16'h1111};
    lat_vec[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 16'h1111};

    resetn = 1'b0;
    applyStimulus(0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0);
    repeat (2) step();

    $display("[TB] reset state");
    checkOutput("rst mem_rd", if0.mem_rd, 0);
    checkOutput("rst mem_addr", if0.mem_addr, 0);
    checkOutput("rst iin", if0.iin, 0);
    checkOutput("rst iin_valid", if0.iin_valid, 0);
    checkOutput("rst pc", if0.pc, 0);
    checkOutput("rst halted", if0.halted, 0);
    checkOutput("rst underrun", if0.underrun, 0);
    checkOutput("rst dut1 pc", if1.pc, 8'hFE);
    resetn = 1'b1;
    step();

    $display("[TB] latency and backpressure");
    base = addr_seq0.size();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, lat_vec[i].run, lat_vec[i].done);
      step();
      checkOutput($sformatf("lat[%0d] mem_rd", i), if0.mem_rd, lat_vec[i].exp_rd);
      if (lat_vec[i].exp_rd)
        checkOutput($sformatf("lat[%0d] mem_addr", i), if0.mem_addr, lat_vec[i].exp_addr);
      checkOutput($sformatf("lat[%0d] pc", i), if0.pc, lat_vec[i].exp_pc);
      checkOutput($sformatf("lat[%0d] iin_valid", i), if0.iin_valid, lat_vec[i].exp_valid);
      if (lat_vec[i].exp_valid)
        checkOutput($sformatf("lat[%0d] iin", i), if0.iin, lat_vec[i].exp_iin);
    end
    checkOutput("lat fifo count", dut0.u_fifo.count, 2);

    $display("[TB] program to HALT");
    sb0.push_back(16'h1111); sb0.push_back(16'h2222); sb0.push_back(16'h3333);
    spacedDone(0, 3);
    waitHalted(0);
    checkOutput("prog iin_valid", if0.iin_valid, 0);
    checkOutput("prog iin", if0.iin, 16'hFFFF);
    checkOutput("prog pc", if0.pc, 8'h04);
    checkOutput("prog sb0 empty", sb0.size(), 0);
    checkOutput("prog underrun", if0.underrun, 0);
    max_addr = 0;
    for (int i = base; i < addr_seq0.size(); i++)
      if (int'(addr_seq0[i]) > max_addr) max_addr = int'(addr_seq0[i]);
    checkOutput("prog max mem_addr", max_addr, 3);

    $display("[TB] done every valid cycle");
    applyStimulus(0, 1'b0, 1'b0);
    repeat (2) step();
    checkOutput("halted cleared", if0.halted, 0);
    sb0.push_back(16'h1111); sb0.push_back(16'h2222); sb0.push_back(16'h3333);
    applyStimulus(0, 1'b1, 1'b0);
    begin
      int n = 0;
      while (!if0.halted && n < 40) begin
        step();
        applyStimulus(0, 1'b1, if0.iin_valid);
        n++;
      end
    end
    applyStimulus(0, 1'b1, 1'b0);
    checkOutput("b2b halted", if0.halted, 1);
    checkOutput("b2b sb0 empty", sb0.size(), 0);
    checkOutput("b2b underrun clear", if0.underrun, 0);
    applyStimulus(0, 1'b1, 1'b1);
    step();
    applyStimulus(0, 1'b1, 1'b0);
    checkOutput("underrun set", if0.underrun, 1);
    applyStimulus(0, 1'b0, 1'b0);
    repeat (2) step();
    checkOutput("underrun sticky", if0.underrun, 1);

    $display("[TB] pc wrap");
    base = addr_seq1.size();
    sb1.push_back(16'hAAAA); sb1.push_back(16'hBBBB);
    applyStimulus(1, 1'b1, 1'b0);
    spacedDone(1, 2);
    waitHalted(1);
    checkOutput("wrap pc", if1.pc, 8'h01);
    checkOutput("wrap iin", if1.iin, 16'hFFFF);
    checkOutput("wrap sb1 empty", sb1.size(), 0);
    checkOutput("wrap read count", addr_seq1.size() - base, 3);
    if (addr_seq1.size() - base == 3) begin
      checkOutput("wrap addr0", addr_seq1[base], 8'hFE);
      checkOutput("wrap addr1", addr_seq1[base + 1], 8'hFF);
      checkOutput("wrap addr2", addr_seq1[base + 2], 8'h00);
    end
    applyStimulus(1, 1'b0, 1'b0);

    $display("[TB] drain and restart");
    applyStimulus(0, 1'b1, 1'b0);
    step();
    checkOutput("drain first rd", if0.mem_rd, 1);
    checkOutput("drain first addr", if0.mem_addr, 0);
    checkOutput("restart clears underrun", if0.underrun, 0);
    applyStimulus(0, 1'b0, 1'b0);
    step();
    checkOutput("drain no rd", if0.mem_rd, 0);
    base = addr_seq0.size();
    step();
    checkOutput("drain iin_valid", if0.iin_valid, 1);
    checkOutput("drain iin", if0.iin, 16'h1111);
    sb0.push_back(16'h1111);
    applyStimulus(0, 1'b0, 1'b1);
    step();
    applyStimulus(0, 1'b0, 1'b0);
    repeat (4) step();
    checkOutput("drain reads after run low", addr_seq0.size() - base, 0);
    checkOutput("drain idle valid", if0.iin_valid, 0);
    checkOutput("drain pc", if0.pc, 8'h01);
    checkOutput("drain sb0 empty", sb0.size(), 0);
    applyStimulus(0, 1'b1, 1'b0);
    step();
    checkOutput("restart rd", if0.mem_rd, 1);
    checkOutput("restart addr", if0.mem_addr, 0);
    checkOutput("restart pc", if0.pc, 1);
    repeat (5) step();
    checkOutput("fill iin_valid", if0.iin_valid, 1);
    checkOutput("fill iin", if0.iin, 16'h1111);
    checkOutput("fill count", dut0.u_fifo.count, 2);

    $display("[TB] async reset mid-cycle");
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("arst mem_rd", if0.mem_rd, 0);
    checkOutput("arst iin", if0.iin, 0);
    checkOutput("arst iin_valid", if0.iin_valid, 0);
    checkOutput("arst pc", if0.pc, 0);
    checkOutput("arst halted", if0.halted, 0);
    checkOutput("arst count", dut0.u_fifo.count, 0);
    checkOutput("arst dut1 pc", if1.pc, 8'hFE);
    applyStimulus(0, 1'b0, 1'b0);
    repeat (2) step();
    resetn = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction supplier for the processor's `iin` port; it is the producer side of the instruction interface the processor consumes.
- Holds a program counter and issues sequential reads to a synchronous program memory with a fixed 1-cycle read latency.
- Buffers fetched words in a small prefetch FIFO and presents the head word on `iin` until the processor signals completion on `done` (the control unit's clear pulse).
- Stops when it reaches a HALT word.

Parameters:
- ADDR_W, 8, program memory address width.
- DEPTH, 2, prefetch FIFO depth (power of two, >=2).
- START_ADDR, 0, PC value loaded on reset and on every start.
- HALT_WORD, 16'hFFFF, instruction encoding that terminates fetch.

Ports:
- clock  in  1  single system clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- run  in  1  level; high starts/continues fetch, low requests drain to IDLE.
- done  in  1  one-cycle pulse from the processor: current `iin` instruction finished.
- mem_rd  out  1  registered read strobe to program memory.
- mem_addr  out  ADDR_W  registered read address, valid while mem_rd=1.
- mem_data  in  16  read data, valid exactly one cycle after the mem_rd cycle.
- iin  out  16  instruction to processor (FIFO head).
- iin_valid  out  1  iin holds a real instruction.
- pc  out  ADDR_W  address of the next read to issue.
- halted  out  1  HALT word reached the FIFO head.
- underrun  out  1  sticky; set by done while iin_valid=0.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, pc=START_ADDR, mem_rd=0, mem_addr=0.
  - FIFO empty, in-flight flag=0, iin=0, iin_valid=0, halted=0, underrun=0.
- States: IDLE, RUN, DRAIN, HALTED.
- IDLE:
  - No reads issued.
  - run=1 sampled → RUN. At the same edge: pc=START_ADDR, FIFO flushed, underrun cleared.
- RUN, read issue:
  - A read is issued when (FIFO count + in-flight) < DEPTH and no HALT word has been fetched.
  - Count is the pre-pop value, which is deliberately conservative.
  - On issue, at the edge: mem_rd=1, mem_addr=pc, pc=pc+1 modulo 2^ADDR_W (wraps to 0 after max).
  - mem_rd is deasserted on every cycle no read is issued.
- In-flight data:
  - One cycle after mem_rd=1, mem_data is pushed into the FIFO at the next edge.
  - The push can never overflow, because of the issue rule.
- HALT word:
  - When a pushed word equals HALT_WORD, read issue stops permanently until restart.
  - The HALT word is stored in the FIFO normally.
- Presentation:
  - iin = FIFO head data.
  - iin_valid = FIFO non-empty AND head != HALT_WORD.
  - iin stays stable while done=0.
- Pop:
  - done=1 with iin_valid=1 pops the head at the edge.
  - The next word (if present) appears on iin in the following cycle.
  - Simultaneous push and pop in the same cycle is legal; count is unchanged.
- done with iin_valid=0: ignored (no pop), underrun←1.
- Halt at head:
  - When the HALT word becomes the head → HALTED, halted=1, iin=HALT_WORD, iin_valid=0.
- HALTED:
  - Holds until run=0 is sampled → IDLE, with halted cleared.
  - run held high keeps HALTED (no auto-restart).
- run=0 in RUN → DRAIN:
  - No new reads; the outstanding in-flight word is still pushed.
  - FIFO contents are still presented and popped.
  - FIFO empty and no in-flight → IDLE.
  - HALT at head during DRAIN → HALTED.
  - run=1 in DRAIN → back to RUN without flush; pc continues.
- Latency: run sampled at edge N:
  - mem_rd=1 after edge N.
  - Data pushed at edge N+2.
  - iin_valid=1 from edge N+2.
- Steady state: the memory is read once per done; throughput is one instruction per processor completion.
- Reset mid-operation: asynchronous clear to the reset values above. Any in-flight memory data is discarded.

Decomposition:
- Shared package `fetch_pkg`: state encoding (IDLE, RUN, DRAIN, HALTED), HALT_WORD default, MEM_LAT=1 constant.
- One sub-module, `fetch_fifo`:
  - Width 16, depth DEPTH.
  - Ports: push, pop, wdata, head, count, empty, full, flush.
  - Simultaneous push/pop supported.
- `instr_fetch` holds the FSM, PC, in-flight flag, and halt detect.

Test Plan:
- Program 0:1111, 1:2222, 2:3333, 3:FFFF; run=1, done pulsed 3 cycles after each iin_valid rise → iin sequence 1111, 2222, 3333, then halted=1, iin_valid=0, mem_addr never exceeds 3.
- Latency/backpressure: run at edge N, done never asserted → mem_rd at addrs 0 and 1 only, iin=1111 valid from N+2 and stable, FIFO count=2, pc=2.
- Wrap: START_ADDR=8'hFE, memory FE:AAAA, FF:BBBB, 00:FFFF → mem_addr sequence FE, FF, 00; iin AAAA then BBBB; pc reads 01 when halted.
- done every cycle with 3 consecutive words, pushes coinciding with pops → no lost or duplicated word; underrun stays 0 unless done hits a cycle with iin_valid=0, which must then set underrun=1.
- run dropped after first read issued → DRAIN, in-flight 1111 still presented; after its done → IDLE, no further mem_rd; run=1 again → restart from START_ADDR.
- resetn=0 asserted mid-cycle while FIFO holds 2 words → all outputs immediately at reset values (mem_rd=0, iin=0, iin_valid=0, pc=START_ADDR) without waiting for a clock edge.
